// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the trap (exception) controller.
//   state_t              controller FSM states
//   CAUSE_ILLEGAL        cause code for an illegal instruction
//   CAUSE_ECALL          cause code for an environment call
//   DEFAULT_TRAP_VECTOR  default handler entry address
package trap_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ENTER,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } state_t;

  localparam logic [3:0]  CAUSE_ILLEGAL       = 4'd2;
  localparam logic [3:0]  CAUSE_ECALL         = 4'd11;
  localparam int unsigned DEFAULT_TRAP_VECTOR = 96;

endpackage

// File: rtl/trap_unit.sv
// trap_unit: exception controller beside decode. It captures the faulting PC
// and cause, pulses a one-cycle redirect to the handler vector, tracks handler
// occupancy, returns to epc+4 on MRET and halts on a fault inside the handler.
//
// Optional feature: define TRAP_ECALL_EN to make ECALL trap (cause 11) and to
// make an ECALL inside the handler a double fault. Without it, ecall is ignored.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        synchronous reset, active-low
//   instr_valid  decode holds a real instruction
//   pc           PC of the instruction in decode
//   invalid      illegal opcode flag
//   ecall        decoded ECALL
//   mret         decoded MRET
//   redirect     one-cycle pulse to load redirect_pc and flush IF/ID
//   redirect_pc  redirect target (zero when redirect is low)
//   epc          saved faulting PC
//   cause        trap cause
//   in_handler   handler executing
//   halted       double fault, sticky until reset
//   trap_count   traps taken, saturating
module trap_unit
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic             invalid,
  input  logic             ecall,
  input  logic             mret,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  epc,
  output logic [3:0]       cause,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] trap_count
);

  state_t     state;
  logic       take_trap;
  logic [3:0] trap_cause;
  logic       double_fault;

  // Trap qualification; invalid outranks ecall when both are flagged.
  always_comb begin
    take_trap    = instr_valid & invalid;
    trap_cause   = CAUSE_ILLEGAL;
    double_fault = instr_valid & invalid;
`ifdef TRAP_ECALL_EN
    if (instr_valid & ecall & ~invalid) begin
      take_trap  = 1'b1;
      trap_cause = CAUSE_ECALL;
    end
    double_fault = instr_valid & (invalid | ecall);
`endif
  end

`ifndef TRAP_ECALL_EN
  logic unused_ecall;
  assign unused_ecall = ecall;
`endif

  // Outputs are registered on the transition edge so that redirect, the
  // captured epc/cause and in_handler all appear together one cycle after
  // the triggering instruction. ENTER/RETURN are the redirect cycles, in
  // which decode holds a flushed instruction and inputs are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      cause       <= '0;
      in_handler  <= 1'b0;
      halted      <= 1'b0;
      trap_count  <= '0;
    end else begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      unique case (state)
        ST_RUN: begin
          if (take_trap) begin
            epc         <= pc;
            cause       <= trap_cause;
            if (trap_count != {CNT_W{1'b1}})
              trap_count <= trap_count + CNT_W'(1);
            redirect    <= 1'b1;
            redirect_pc <= TRAP_VECTOR;
            in_handler  <= 1'b1;
            state       <= ST_ENTER;
          end
        end
        ST_ENTER: state <= ST_HANDLER;
        ST_HANDLER: begin
          if (double_fault) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (instr_valid & mret) begin
            redirect    <= 1'b1;
            redirect_pc <= epc + XLEN'(4);
            in_handler  <= 1'b0;
            state       <= ST_RETURN;
          end
        end
        ST_RETURN: state <= ST_RUN;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule
